// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and sizing for the boot-time program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        LOAD = 3'd1,
        CHK  = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } state_t;

    function automatic int unsigned max_words(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    localparam int unsigned MAX_WORDS = max_words(ADDR_W);

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_if
//  Description : Program stream (valid/ready) and instruction-memory write bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if
    import loader_pkg::*;
#(
    parameter int N = DATA_W,
    parameter int A = ADDR_W
);
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         in_ready;
    logic         imem_we;
    logic [A-1:0] imem_addr;
    logic [N-1:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/loader_cksum.sv
`default_nettype none
// ============================================================================
//  Module      : loader_cksum
//  Description : Modulo-2**N payload accumulator with equality compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_cksum
    import loader_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         add_en,
    input  logic [N-1:0] add_data,
    input  logic [N-1:0] cmp_data,
    output logic         match
);
    logic [N-1:0] r_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
        end else if (clr) begin
            r_sum <= '0;
        end else if (add_en) begin
            r_sum <= r_sum + add_data;
        end
    end

    assign match = (r_sum == cmp_data);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Loads a framed, checksummed program into imem, then releases
//                the CPU from reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter int N = DATA_W,
    parameter int A = ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus,
    input  logic         start,
    output logic         cpu_reset,
    output logic         done,
    output logic         error,
    output logic [A:0]   load_count
);
    localparam logic [N-1:0] c_max_words = N'(max_words(A));
    localparam logic [A:0]   c_one       = (A+1)'(1);

    state_t       r_state;
    state_t       w_next;
    logic [A:0]   r_remaining;
    logic [A:0]   r_count;
    logic         r_we;
    logic [A-1:0] r_addr;
    logic [N-1:0] r_wdata;
    logic         w_xfer;
    logic         w_load_xfer;
    logic         w_arm;
    logic         w_len_bad;
    logic         w_sum_clr;
    logic         w_sum_add;
    logic         w_match;

    assign bus.in_ready = (r_state == HDR) || (r_state == LOAD) || (r_state == CHK);
    assign w_xfer       = bus.in_valid && bus.in_ready;
    assign w_load_xfer  = w_xfer && (r_state == LOAD);
    assign w_arm        = start && ((r_state == RUN) || (r_state == ERR));
    assign w_len_bad    = bus.in_data > c_max_words;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_sum_clr = 1'b0;
        w_sum_add = 1'b0;
        unique case (r_state)
            HDR: begin
                if (w_xfer) begin
                    w_sum_clr = 1'b1;
                    if (w_len_bad)                w_next = ERR;
                    else if (bus.in_data == '0)   w_next = CHK;
                    else                          w_next = LOAD;
                end
            end
            LOAD: begin
                if (w_xfer) begin
                    w_sum_add = 1'b1;
                    if (r_remaining == c_one) w_next = CHK;
                end
            end
            CHK: begin
                if (w_xfer) w_next = w_match ? RUN : ERR;
            end
            RUN, ERR: begin
                if (start) begin
                    w_next    = HDR;
                    w_sum_clr = 1'b1;
                end
            end
            default: w_next = HDR;
        endcase
    end

    // Address tracks load_count: both restart at zero on every arm/reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_remaining <= '0;
            r_count     <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_we <= w_load_xfer;
            if (w_xfer && (r_state == HDR)) begin
                r_remaining <= bus.in_data[A:0];
            end else if (w_load_xfer) begin
                r_remaining <= r_remaining - c_one;
            end
            if (w_load_xfer) begin
                r_addr  <= r_count[A-1:0];
                r_wdata <= bus.in_data;
                r_count <= r_count + c_one;
            end else if (w_arm) begin
                r_count <= '0;
            end
        end
    end

    loader_cksum #(.N(N)) u_cksum (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_sum_clr),
        .add_en   (w_sum_add),
        .add_data (bus.in_data),
        .cmp_data (bus.in_data),
        .match    (w_match)
    );

    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign load_count     = r_count;
    assign done           = (r_state == RUN);
    assign error          = (r_state == ERR);
    assign cpu_reset      = (r_state != RUN);

endmodule
`default_nettype wire
